// File: rtl/mem_stage_pkg.sv
// Shared widths and the EX/MEM pipeline record for the memory stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // One EX/MEM pipeline slot: control bits plus the data it carries.
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [REG_AW-1:0] writereg;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
  } exm_t;

  // A bubble is an all-zero slot: no register write, no memory access.
  localparam exm_t EXM_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_reg_mem.sv
// EX/MEM pipeline register with hold (stall) and bubble insert (flush).
// Latency: 1 cycle from d_i to q_o.
// Backpressure: StallM holds the slot; FlushM wins over StallM.
// Ports: Clk, rst (async active-low), StallM, FlushM, d_i (EX slot), q_o (M slot).
module REG_MEM
  import mem_stage_pkg::*;
(
  input  logic Clk,
  input  logic rst,
  input  logic StallM,
  input  logic FlushM,
  input  exm_t d_i,
  output exm_t q_o
);

  exm_t slot_q;
  exm_t slot_d;

  always_comb begin
    slot_d = d_i;
    if (FlushM) begin
      slot_d = EXM_BUBBLE;
    end else if (StallM) begin
      slot_d = slot_q;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      slot_q <= EXM_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, word-addressed data memory,
// misalignment flag and sticky error. Latency: 1 cycle EX->M; RD is
// combinational from ALUOutM. Backpressure: none generated; StallM holds.
// Ports: *E execute-stage inputs, StallM/FlushM pipeline control,
// *M registered outputs, RD read data, MisalignM, ErrSticky.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic [REG_AW-1:0] WriteRegM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] RD,
  output logic              MisalignM,
  output logic              ErrSticky
);

  exm_t ex_slot;
  exm_t m_slot;

  assign ex_slot = '{regwrite:  RegWriteE,
                     memtoreg:  MemtoRegE,
                     memwrite:  MemWriteE,
                     writereg:  WriteRegE,
                     aluout:    ALUOutE,
                     writedata: WriteDataE};

  REG_MEM u_reg_mem (
    .Clk    (Clk),
    .rst    (rst),
    .StallM (StallM),
    .FlushM (FlushM),
    .d_i    (ex_slot),
    .q_o    (m_slot)
  );

  assign RegWriteM = m_slot.regwrite;
  assign MemtoRegM = m_slot.memtoreg;
  assign WriteRegM = m_slot.writereg;
  assign ALUOutM   = m_slot.aluout;

  // Byte address truncated to a word index; upper bits wrap modulo DEPTH*4.
  logic [AW-1:0] word_addr;
  assign word_addr = m_slot.aluout[AW+1:2];

  assign MisalignM = (m_slot.memwrite | m_slot.memtoreg) & (m_slot.aluout[1:0] != 2'b00);

  // A stalled or misaligned store never touches the array.
  logic mem_we;
  assign mem_we = m_slot.memwrite & ~StallM & ~MisalignM;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read is combinational, so a same-address store shows its new data
  // only after the edge that commits it.
  assign RD = mem_q[word_addr];

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[word_addr] <= m_slot.writedata;
    end
  end

  logic err_q;
  logic err_d;

  assign err_d = err_q | (MisalignM & ~StallM);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ErrSticky = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (DEPTH=64).
// Latency: inputs driven 1 time unit after a rising edge, checked after the next.
// Backpressure: StallM/FlushM driven directly by the bench.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUOutE, WriteDataE;
  logic        StallM, FlushM;
  logic        RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, RD;
  logic        MisalignM, ErrSticky;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DEPTH(64), .AW(6)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .WriteRegE  (WriteRegE),
    .ALUOutE    (ALUOutE),
    .WriteDataE (WriteDataE),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .WriteRegM  (WriteRegM),
    .ALUOutM    (ALUOutM),
    .RD         (RD),
    .MisalignM  (MisalignM),
    .ErrSticky  (ErrSticky)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic rw, input logic m2r, input logic mw,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic st, input logic fl);
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw; WriteRegE = wr;
    ALUOutE = alu; WriteDataE = wd; StallM = st; FlushM = fl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 5'd9, 32'h0000_0013, 32'hFFFF_FFFF, 0, 0);
    #1 rst = 1'b0;
    #2;
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b want=0", RegWriteM); end
    checks++; if (MemtoRegM !== 1'b0) begin failures++; $display("FAIL reset_memtoreg got=%b want=0", MemtoRegM); end
    checks++; if (WriteRegM !== 5'd0) begin failures++; $display("FAIL reset_writereg got=%0d want=0", WriteRegM); end
    checks++; if (ALUOutM !== 32'd0) begin failures++; $display("FAIL reset_aluout got=%h want=0", ALUOutM); end
    checks++; if (RD !== 32'd0) begin failures++; $display("FAIL reset_rd got=%h want=0", RD); end
    checks++; if (MisalignM !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b want=0", MisalignM); end
    checks++; if (ErrSticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", ErrSticky); end
    // Edges while in reset must not load the pipeline.
    tick(); tick();
    checks++; if (ALUOutM !== 32'd0 || RegWriteM !== 1'b0) begin failures++; $display("FAIL reset_hold alu=%h rw=%b want=0/0", ALUOutM, RegWriteM); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    drive(0, 0, 1, 5'd0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    tick();
    checks++; if (RD !== 32'd0) begin failures++; $display("FAIL sl_store_cycle_rd got=%h want=0", RD); end
    drive(1, 1, 0, 5'd5, 32'h10, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sl_load_rd got=%h want=deadbeef", RD); end
    checks++; if (MemtoRegM !== 1'b1 || RegWriteM !== 1'b1) begin failures++; $display("FAIL sl_load_ctrl m2r=%b rw=%b want=1/1", MemtoRegM, RegWriteM); end
    checks++; if (WriteRegM !== 5'd5 || ALUOutM !== 32'h10) begin failures++; $display("FAIL sl_load_fields wr=%0d alu=%h want=5/10", WriteRegM, ALUOutM); end
    checks++; if (MisalignM !== 1'b0) begin failures++; $display("FAIL sl_misalign got=%b want=0", MisalignM); end
  endtask

  task automatic test_misalign();
    drive(0, 0, 1, 5'd0, 32'h13, 32'h1234, 0, 0);
    tick();
    checks++; if (MisalignM !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b want=1", MisalignM); end
    checks++; if (ErrSticky !== 1'b0) begin failures++; $display("FAIL mis_err_early got=%b want=0", ErrSticky); end
    // Misaligned load at 0x11 still reads word 4.
    drive(1, 1, 0, 5'd3, 32'h11, 32'h0, 0, 0);
    tick();
    checks++; if (ErrSticky !== 1'b1) begin failures++; $display("FAIL mis_err_set got=%b want=1", ErrSticky); end
    checks++; if (RD !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_mem_unchanged got=%h want=deadbeef", RD); end
    checks++; if (MisalignM !== 1'b1) begin failures++; $display("FAIL mis_load_flag got=%b want=1", MisalignM); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (ErrSticky !== 1'b1) begin failures++; $display("FAIL mis_err_hold cyc=%0d got=%b want=1", i, ErrSticky); end
    end
    checks++; if (MisalignM !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b want=0", MisalignM); end
  endtask

  task automatic test_stall_flush();
    drive(0, 0, 1, 5'd0, 32'h30, 32'hCAFE_0001, 0, 0);
    tick();
    drive(1, 1, 0, 5'd12, 32'h40, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ALUOutM !== 32'h30 || RegWriteM !== 1'b0 || WriteRegM !== 5'd0) begin
        failures++; $display("FAIL stall_frozen cyc=%0d alu=%h rw=%b wr=%0d want=30/0/0", i, ALUOutM, RegWriteM, WriteRegM);
      end
      checks++; if (RD !== 32'd0) begin failures++; $display("FAIL stall_nowrite cyc=%0d got=%h want=0", i, RD); end
    end
    FlushM = 1'b1;
    tick();
    checks++; if (RegWriteM !== 1'b0 || ALUOutM !== 32'd0 || MemtoRegM !== 1'b0) begin
      failures++; $display("FAIL flush_bubble rw=%b alu=%h m2r=%b want=0/0/0", RegWriteM, ALUOutM, MemtoRegM);
    end
    checks++; if (MisalignM !== 1'b0 || WriteRegM !== 5'd0) begin failures++; $display("FAIL flush_fields mis=%b wr=%0d want=0/0", MisalignM, WriteRegM); end
    drive(1, 1, 0, 5'd2, 32'h30, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'd0) begin failures++; $display("FAIL stall_store_dropped got=%h want=0", RD); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 5'd0, 32'h100, 32'hA5A5_A5A5, 0, 0);
    tick();
    drive(1, 1, 0, 5'd1, 32'h000, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wrap_rd0 got=%h want=a5a5a5a5", RD); end
    drive(1, 1, 0, 5'd1, 32'h200, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wrap_rd200 got=%h want=a5a5a5a5", RD); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1, 5'd0, 32'h20, 32'h11, 0, 0);
    tick();
    drive(0, 0, 1, 5'd0, 32'h20, 32'h55, 0, 0);
    tick();
    checks++; if (RD !== 32'h11) begin failures++; $display("FAIL rdw_old got=%h want=11", RD); end
    drive(1, 1, 0, 5'd4, 32'h20, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'h55) begin failures++; $display("FAIL rdw_new got=%h want=55", RD); end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 5'd0, 32'h24, 32'h77, 0, 0);
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (RegWriteM !== 1'b0 || MemtoRegM !== 1'b0 || WriteRegM !== 5'd0 || ALUOutM !== 32'd0) begin
      failures++; $display("FAIL arst_outputs rw=%b m2r=%b wr=%0d alu=%h want=0", RegWriteM, MemtoRegM, WriteRegM, ALUOutM);
    end
    checks++; if (RD !== 32'd0 || MisalignM !== 1'b0) begin failures++; $display("FAIL arst_rd rd=%h mis=%b want=0/0", RD, MisalignM); end
    checks++; if (ErrSticky !== 1'b0) begin failures++; $display("FAIL arst_err got=%b want=0", ErrSticky); end
    drive(1, 1, 0, 5'd6, 32'h24, 32'h0, 0, 0);
    #1 rst = 1'b1;
    tick();
    checks++; if (RD !== 32'd0) begin failures++; $display("FAIL arst_store_dropped got=%h want=0", RD); end
    checks++; if (ALUOutM !== 32'h24 || WriteRegM !== 5'd6) begin failures++; $display("FAIL arst_release alu=%h wr=%0d want=24/6", ALUOutM, WriteRegM); end
    drive(1, 1, 0, 5'd6, 32'h10, 32'h0, 0, 0);
    tick();
    checks++; if (RD !== 32'd0) begin failures++; $display("FAIL arst_mem_cleared got=%h want=0", RD); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misalign();
    test_stall_flush();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
